// File: rtl/data_mem_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : data_mem_ctrl_if                                                |
// | Brief    : Request/response bus between the core MEM stage and data memory |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_busy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        access_err;

    modport master (
        output req,
        output we,
        output funct3,
        output addr,
        output wdata,
        input  mem_busy,
        input  rvalid,
        input  rdata,
        input  access_err
    );

    modport slave (
        input  req,
        input  we,
        input  funct3,
        input  addr,
        input  wdata,
        output mem_busy,
        output rvalid,
        output rdata,
        output access_err
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                   |
// | Brief    : Wait-state data memory with RV32 byte/half/word load and store  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    data_mem_ctrl_if.slave bus
);

    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [c_AW+1:0]   r_addr;
    logic [31:0]       r_wdata;
    logic              r_mem_busy;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_access_err;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic [c_AW-1:0]   w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic              w_err;
    logic [3:0]        w_be;
    logic [31:0]       w_wrep;
    logic              w_wr_en;
    logic              w_unused_addr;

    // Bits above the word index only alias into the same array.
    assign w_unused_addr = &{1'b0, bus.addr[31:c_AW+2]};

    assign w_idx  = r_addr[c_AW+1:2];
    assign w_lane = r_addr[1:0];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_err = 1'b1;
        case (r_funct3)
            3'b000:  w_err = 1'b0;
            3'b100:  w_err = r_we;
            3'b001:  w_err = r_addr[0];
            3'b101:  w_err = r_addr[0] | r_we;
            3'b010:  w_err = |r_addr[1:0];
            default: w_err = 1'b1;
        endcase
    end

    // Alignment is guaranteed for non-error accesses, so a lane shift suffices.
    always_comb begin
        w_shifted = w_word >> {w_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_be   = 4'b0000;
        w_wrep = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wrep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_wrep = r_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_wrep = r_wdata;
            end
        endcase
    end

    // Qualified by reset_n so a store cut short by reset never reaches the array.
    assign w_wr_en = (r_state == S_ACCESS) && r_we && !w_err && reset_n;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_mem_busy   <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= 32'd0;
            r_access_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we       <= bus.we;
                        r_funct3   <= bus.funct3;
                        r_addr     <= bus.addr[c_AW+1:0];
                        r_wdata    <= bus.wdata;
                        r_cnt      <= c_WAIT;
                        r_mem_busy <= 1'b1;
                        r_state    <= (c_WAIT == 4'd0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_mem_busy   <= 1'b0;
                    r_rvalid     <= 1'b1;
                    r_access_err <= w_err;
                    if (w_err) begin
                        r_rdata <= 32'd0;
                    end else if (!r_we) begin
                        r_rdata <= w_load;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_rvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_busy   = r_mem_busy;
    assign bus.rvalid     = r_rvalid;
    assign bus.rdata      = r_rdata;
    assign bus.access_err = r_access_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_ctrl                                                |
// | Brief    : Directed and random checks of data_mem_ctrl against a model     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_ctrl;
    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level reference: byte-addressed memory image and pending request
    logic [31:0] mmem [DEPTH];
    bit          p_valid = 1'b0;
    int          p_acc;
    bit          p_we;
    logic [2:0]  p_f3;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] exp_rdata = 32'd0;
    bit          chk_en = 1'b0;

    function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3[2]) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        if (f3[1:0] == 2'b00) begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int idx, size, lane;
        idx  = (a / 4) % DEPTH;
        size = 1 << f3[1:0];
        lane = a % 4;
        for (int b = 0; b < size; b++) mmem[idx][8*(lane+b) +: 8] = wd[8*b +: 8];
    endfunction

    bit c_busy_e, c_rv_e, c_err_e;
    always @(negedge clk) begin
        if (chk_en) begin
            c_busy_e = p_valid && cyc >= p_acc && cyc <= p_acc + W;
            c_rv_e   = p_valid && cyc == p_acc + W + 1;
            c_err_e  = 1'b0;
            if (c_rv_e) begin
                c_err_e = ref_err(p_we, p_f3, p_addr);
                if (c_err_e) exp_rdata = 32'd0;
                else if (!p_we) exp_rdata = ref_load(mmem[(p_addr / 4) % DEPTH], p_f3, p_addr);
                else ref_store(p_f3, p_addr, p_wdata);
                p_valid = 1'b0;
            end
            check("mem_busy", {31'd0, bus.mem_busy}, {31'd0, c_busy_e});
            check("rvalid", {31'd0, bus.rvalid}, {31'd0, c_rv_e});
            check("rdata", bus.rdata, exp_rdata);
            if (c_rv_e) check("access_err", {31'd0, bus.access_err}, {31'd0, c_err_e});
        end
    end

    logic [31:0] t_rd;
    logic        t_er;
    logic [3:0]  t_bh, t_rh;
    int          rv_count;

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit garble);
        bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        p_we = we; p_f3 = f3; p_addr = a; p_wdata = wd; p_acc = cyc + 1; p_valid = 1'b1;
        @(posedge clk);
        rv_count = 0;
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            t_bh[k] = bus.mem_busy;
            t_rh[k] = bus.rvalid;
            if (bus.rvalid) rv_count++;
            if (k == W + 1) begin
                t_rd = bus.rdata;
                t_er = bus.access_err;
            end
            if (garble) begin
                bus.req = 1'b1; bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
                bus.addr = $urandom; bus.wdata = $urandom;
            end else begin
                bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
        if (bus.rvalid) rv_count++;
    endtask

    task automatic expect_load(input string name, input logic [31:0] exp_val, input bit exp_e);
        check({name, " rdata"}, t_rd, exp_val);
        check({name, " err"}, {31'd0, t_er}, {31'd0, exp_e});
    endtask

    logic [31:0] r_addr_rand;
    initial begin
        reset_n = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_busy", {31'd0, bus.mem_busy}, 32'd0);
        check("reset rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        check("reset access_err", {31'd0, bus.access_err}, 32'd0);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        check("latency busy pattern", {28'd0, t_bh}, 32'h7);
        check("latency rvalid pattern", {28'd0, t_rh}, 32'h8);
        check("SW err", {31'd0, t_er}, 32'd0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); expect_load("LW", 32'hDEADBEEF, 1'b0);
        txn(1'b0, 3'b000, 32'h10, 32'd0, 1'b0); expect_load("LB", 32'hFFFFFFEF, 1'b0);
        txn(1'b0, 3'b100, 32'h10, 32'd0, 1'b0); expect_load("LBU", 32'h000000EF, 1'b0);
        txn(1'b0, 3'b001, 32'h12, 32'd0, 1'b0); expect_load("LH", 32'hFFFFDEAD, 1'b0);
        txn(1'b0, 3'b101, 32'h12, 32'd0, 1'b0); expect_load("LHU", 32'h0000DEAD, 1'b0);
        txn(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); expect_load("LW after SH", 32'hABCDBEEF, 1'b0);
        txn(1'b1, 3'b000, 32'h11, 32'h00000055, 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); expect_load("LW after SB", 32'hABCD55EF, 1'b0);
        txn(1'b0, 3'b010, 32'h13, 32'd0, 1'b0); expect_load("LW misaligned", 32'h0, 1'b1);
        txn(1'b1, 3'b010, 32'h12, 32'h11111111, 1'b0);
        check("SW misaligned err", {31'd0, t_er}, 32'd1);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); expect_load("LW after bad SW", 32'hABCD55EF, 1'b0);
        txn(1'b0, 3'b011, 32'h10, 32'd0, 1'b0); expect_load("funct3 011", 32'h0, 1'b1);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b1); expect_load("LW garbled inputs", 32'hABCD55EF, 1'b0);
        check("single rvalid", rv_count, 32'd1);

        // Reset during WAIT of SW 0 @0x10
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h10; bus.wdata = 32'd0;
        p_we = 1'b1; p_f3 = 3'b010; p_addr = 32'h10; p_wdata = 32'd0; p_acc = cyc + 1; p_valid = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0; bus.req = 1'b0; p_valid = 1'b0; exp_rdata = 32'd0;
        #1;
        check("reset mid busy", {31'd0, bus.mem_busy}, 32'd0);
        check("reset mid rvalid", {31'd0, bus.rvalid}, 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); expect_load("LW after reset", 32'hABCD55EF, 1'b0);

        txn(1'b1, 3'b010, 32'h1010, 32'h12345678, 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); expect_load("LW wrap", 32'h12345678, 1'b0);

        // Random phase over words 0..15 with aliased upper address bits
        for (int i = 0; i < 16; i++) txn(1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0);
        for (int n = 0; n < 300; n++) begin
            r_addr_rand = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            txn(1'($urandom), 3'($urandom_range(0, 7)), r_addr_rand, $urandom,
                ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
